// File: rtl/result_writeback.sv
// -----------------------------------------------------------------------------
// result_writeback
//   Collects signed MAC lane results into two ping/pong capture slots and
//   drains them, lowest set lane first, as a stream of single-word writes to a
//   result memory. A run writes result_count words starting at base_addr and
//   then pulses done for one cycle.
//
//   Optional feature (compile-time macro RESULT_WRITEBACK_RELU_EN):
//     defined   - words with the sign bit set are written as zero (ReLU)
//     undefined - every word is written unchanged
//
// Ports
//   clk          clock, all state on rising edge
//   rst          asynchronous active-low reset
//   start        one-cycle pulse arming a run (ignored unless idle)
//   base_addr    first write address, sampled on accepted start
//   result_count words to write, sampled on accepted start (0 = 2^ADDR_W)
//   acc_in_0..3  signed lane results
//   valid_in     per-lane valid, bit i qualifies acc_in_i
//   out_ready    memory accepts a write this cycle
//   out_we       write strobe (write completes when out_we & out_ready)
//   out_addr     write address
//   out_data     write data
//   busy         high while a run is collecting/draining
//   done         one-cycle pulse after the last write completes
//   overflow     sticky: a capture was dropped because both slots were full
// -----------------------------------------------------------------------------
module result_writeback #(
  parameter int unsigned ACC_W  = 16,
  parameter int unsigned N_MACS = 4,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] result_count,
  input  logic [ACC_W-1:0]  acc_in_0,
  input  logic [ACC_W-1:0]  acc_in_1,
  input  logic [ACC_W-1:0]  acc_in_2,
  input  logic [ACC_W-1:0]  acc_in_3,
  input  logic [N_MACS-1:0] valid_in,
  input  logic              out_ready,
  output logic              out_we,
  output logic [ADDR_W-1:0] out_addr,
  output logic [ACC_W-1:0]  out_data,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  localparam int unsigned LANES  = 4;
  localparam int unsigned LANE_W = $clog2(LANES);
  localparam int unsigned REM_W  = ADDR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // A slot is occupied while any lane of its mask is still unwritten.
  typedef struct packed {
    logic [LANES-1:0]            mask;
    logic [LANES-1:0][ACC_W-1:0] data;
  } slot_t;

  // Registered state
  state_t            state_q;
  slot_t             slot_q [2];
  logic              head_q;
  logic [REM_W-1:0]  remaining_q;
  logic [LANE_W-1:0] out_lane_q;

  // Next-state values
  state_t            state_n;
  slot_t             slot_n [2];
  logic              head_n;
  logic [REM_W-1:0]  remaining_n;
  logic [LANE_W-1:0] out_lane_n;
  logic              out_we_n;
  logic [ADDR_W-1:0] out_addr_n;
  logic [ACC_W-1:0]  out_data_n;
  logic              busy_n;
  logic              done_n;
  logic              overflow_n;

  // Per-cycle helpers
  logic                        complete;
  logic [LANES-1:0]            cap_mask;
  logic [LANES-1:0][ACC_W-1:0] cap_data;
  logic                        other;
  logic [LANE_W-1:0]           lane_sel;

  assign complete = out_we & out_ready;
  assign cap_mask = LANES'(valid_in);
  assign cap_data = {acc_in_3, acc_in_2, acc_in_1, acc_in_0};

  // Output activation applied to each word as it is loaded into out_data.
  function automatic logic [ACC_W-1:0] activate(input logic [ACC_W-1:0] w);
`ifdef RESULT_WRITEBACK_RELU_EN
    activate = w[ACC_W-1] ? '0 : w;
`else
    activate = w;
`endif
  endfunction

  // Index of the lowest set lane (0 when the mask is empty).
  function automatic logic [LANE_W-1:0] lowest_lane(input logic [LANES-1:0] m);
    lowest_lane = '0;
    for (int i = int'(LANES) - 1; i >= 0; i--) begin
      if (m[i]) lowest_lane = LANE_W'(i);
    end
  endfunction

  // Next-state and next-output logic.
  always_comb begin
    state_n     = state_q;
    slot_n      = slot_q;
    head_n      = head_q;
    remaining_n = remaining_q;
    out_lane_n  = out_lane_q;
    out_we_n    = out_we;
    out_addr_n  = out_addr;
    out_data_n  = out_data;
    busy_n      = busy;
    done_n      = 1'b0;
    overflow_n  = overflow;
    other       = 1'b0;
    lane_sel    = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_n        = ST_RUN;
          busy_n         = 1'b1;
          overflow_n     = 1'b0;
          out_we_n       = 1'b0;
          out_addr_n     = base_addr;
          head_n         = 1'b0;
          slot_n[0].mask = '0;
          slot_n[1].mask = '0;
          remaining_n    = (result_count == '0) ? {1'b1, {ADDR_W{1'b0}}}
                                                : {1'b0, result_count};
        end
      end

      ST_RUN: begin
        // Retire the word just written; the slot frees when its last lane goes.
        if (complete) begin
          out_addr_n                      = out_addr + ADDR_W'(1);
          remaining_n                     = remaining_q - REM_W'(1);
          slot_n[head_q].mask[out_lane_q] = 1'b0;
          if (slot_n[head_q].mask == '0) head_n = ~head_q;
        end

        if (complete && (remaining_q == REM_W'(1))) begin
          // Final word written: anything still pending is discarded.
          state_n  = ST_DONE;
          busy_n   = 1'b0;
          done_n   = 1'b1;
          out_we_n = 1'b0;
        end else begin
          // Capture into the oldest free position, seeing a slot freed above.
          other = ~head_n;
          if (cap_mask != '0) begin
            if (slot_n[head_n].mask == '0) begin
              slot_n[head_n].mask = cap_mask;
              slot_n[head_n].data = cap_data;
            end else if (slot_n[other].mask == '0) begin
              slot_n[other].mask = cap_mask;
              slot_n[other].data = cap_data;
            end else begin
              overflow_n = 1'b1;
            end
          end

          // Present the next word unless a stalled write must hold.
          if (!out_we || complete) begin
            out_we_n = 1'b0;
            if (slot_n[head_n].mask != '0) begin
              lane_sel   = lowest_lane(slot_n[head_n].mask);
              out_we_n   = 1'b1;
              out_lane_n = lane_sel;
              out_data_n = activate(slot_n[head_n].data[lane_sel]);
            end
          end
        end
      end

      ST_DONE: begin
        state_n = ST_IDLE;
        busy_n  = 1'b0;
      end

      default: begin
        state_n  = ST_IDLE;
        busy_n   = 1'b0;
        out_we_n = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      slot_q[0]   <= '0;
      slot_q[1]   <= '0;
      head_q      <= 1'b0;
      remaining_q <= '0;
      out_lane_q  <= '0;
      out_we      <= 1'b0;
      out_addr    <= '0;
      out_data    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state_q     <= state_n;
      slot_q[0]   <= slot_n[0];
      slot_q[1]   <= slot_n[1];
      head_q      <= head_n;
      remaining_q <= remaining_n;
      out_lane_q  <= out_lane_n;
      out_we      <= out_we_n;
      out_addr    <= out_addr_n;
      out_data    <= out_data_n;
      busy        <= busy_n;
      done        <= done_n;
      overflow    <= overflow_n;
    end
  end

endmodule

// File: tb/tb_result_writeback.sv
// -----------------------------------------------------------------------------
// tb_result_writeback
//   Directed, table-driven bench for result_writeback: single-capture runs from
//   a vector table, then hand-written sequences for back-pressure, slot
//   overflow, same-edge slot reuse, ignored start/valid and reset mid-run.
// -----------------------------------------------------------------------------
module tb_result_writeback;

  localparam int unsigned ACC_W  = 16;
  localparam int unsigned N_MACS = 4;
  localparam int unsigned ADDR_W = 8;

`ifdef RESULT_WRITEBACK_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] result_count;
  logic [ACC_W-1:0]  acc_in_0, acc_in_1, acc_in_2, acc_in_3;
  logic [N_MACS-1:0] valid_in;
  logic              out_ready;
  logic              out_we;
  logic [ADDR_W-1:0] out_addr;
  logic [ACC_W-1:0]  out_data;
  logic              busy;
  logic              done;
  logic              overflow;

  always #5 clk = ~clk;

  result_writeback #(.ACC_W(ACC_W), .N_MACS(N_MACS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .result_count(result_count), .acc_in_0(acc_in_0), .acc_in_1(acc_in_1),
    .acc_in_2(acc_in_2), .acc_in_3(acc_in_3), .valid_in(valid_in),
    .out_ready(out_ready), .out_we(out_we), .out_addr(out_addr),
    .out_data(out_data), .busy(busy), .done(done), .overflow(overflow)
  );

  int checks = 0;
  int errors = 0;

  // Completed writes, recorded mid-cycle just before the completing edge.
  logic [ADDR_W-1:0] wr_addr_q [$];
  logic [ACC_W-1:0]  wr_data_q [$];

  always @(negedge clk) begin
    if (rst && out_we && out_ready) begin
      wr_addr_q.push_back(out_addr);
      wr_data_q.push_back(out_data);
    end
  end

  typedef struct packed {
    logic [7:0]       base;
    logic [7:0]       cnt;
    logic [3:0]       mask;
    logic [3:0][15:0] acc;
    logic [2:0]       n;
    logic [3:0][15:0] exp_d;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_writes();
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  task automatic start_run(input logic [7:0] base, input logic [7:0] cnt);
    start        = 1'b1;
    base_addr    = base;
    result_count = cnt;
    tick();
    start        = 1'b0;
  endtask

  task automatic drive(input logic [3:0] mask, input logic [3:0][15:0] acc);
    valid_in = mask;
    acc_in_0 = acc[0];
    acc_in_1 = acc[1];
    acc_in_2 = acc[2];
    acc_in_3 = acc[3];
  endtask

  // Returns the number of cycles until done is seen, 0 if the budget expires.
  task automatic wait_done(input int budget, output int cycles);
    cycles = 0;
    for (int c = 1; c <= budget; c++) begin
      tick();
      if (done === 1'b1) begin
        cycles = c;
        break;
      end
    end
  endtask

  task automatic check_writes(input string tag, input int n, input logic [7:0] base,
                              input logic [3:0][15:0] exp_d);
    logic [7:0] ea;
    check({tag, "_count"}, wr_addr_q.size(), n);
    for (int k = 0; k < n; k++) begin
      if (k < wr_addr_q.size()) begin
        ea = base + 8'(k);
        check({tag, "_addr"}, wr_addr_q[k], ea);
        check({tag, "_data"}, wr_data_q[k], exp_d[k]);
      end
    end
  endtask

  initial begin
    int cyc;

    start = 1'b0; base_addr = '0; result_count = '0;
    valid_in = '0; out_ready = 1'b1;
    acc_in_0 = '0; acc_in_1 = '0; acc_in_2 = '0; acc_in_3 = '0;

    vecs[0] = '{8'h10, 8'd4, 4'b1111, {16'd4, 16'd3, 16'd2, 16'd1}, 3'd4,
                {16'd4, 16'd3, 16'd2, 16'd1}};
    vecs[1] = '{8'h20, 8'd2, 4'b1010, {16'd9, 16'hBBBB, 16'd7, 16'hAAAA}, 3'd2,
                {16'd0, 16'd0, 16'd9, 16'd7}};
    vecs[2] = '{8'hFE, 8'd4, 4'b1111, {16'h44, 16'h33, 16'h22, 16'h11}, 3'd4,
                {16'h44, 16'h33, 16'h22, 16'h11}};
    vecs[3] = '{8'h40, 8'd1, 4'b0001, {16'd0, 16'd0, 16'd0, 16'hFFFB}, 3'd1,
                {16'd0, 16'd0, 16'd0, (RELU ? 16'h0000 : 16'hFFFB)}};
    vecs[4] = '{8'h50, 8'd2, 4'b1111, {16'd8, 16'd7, 16'd6, 16'd5}, 3'd2,
                {16'd0, 16'd0, 16'd6, 16'd5}};
    vecs[5] = '{8'h70, 8'd3, 4'b0111, {16'd0, 16'h0000, 16'h8000, 16'h7FFF}, 3'd3,
                {16'd0, 16'h0000, (RELU ? 16'h0000 : 16'h8000), 16'h7FFF}};

    // Asynchronous reset state
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    check("rst_out_we", out_we, 0);
    check("rst_out_addr", out_addr, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_overflow", overflow, 0);
    tick(); tick();
    rst = 1'b1;
    tick();

    // Single-capture runs with the memory always ready
    for (int i = 0; i < 6; i++) begin
      clear_writes();
      out_ready = 1'b1;
      start_run(vecs[i].base, vecs[i].cnt);
      check("vec_busy", busy, 1);
      drive(vecs[i].mask, vecs[i].acc);
      tick();
      valid_in = '0;
      check("vec_first_we", out_we, 1);
      check("vec_first_addr", out_addr, vecs[i].base);
      check("vec_first_data", out_data, vecs[i].exp_d[0]);
      wait_done(20, cyc);
      check("vec_done_cycles", cyc, vecs[i].n);
      check("vec_busy_at_done", busy, 0);
      tick();
      check("vec_done_pulse", done, 0);
      check_writes("vec", int'(vecs[i].n), vecs[i].base, vecs[i].exp_d);
    end

    // valid_in while idle is ignored; start while running is ignored
    clear_writes();
    drive(4'b1111, {16'h1, 16'h2, 16'h3, 16'h4});
    tick();
    valid_in = '0;
    check("idle_valid_we", out_we, 0);
    check("idle_valid_ovf", overflow, 0);
    start_run(8'hA0, 8'd2);
    start_run(8'h00, 8'd1);
    check("ign_start_busy", busy, 1);
    drive(4'b0011, {16'h0, 16'h0, 16'h32, 16'h31});
    tick();
    valid_in = '0;
    wait_done(20, cyc);
    check("ign_start_cycles", cyc, 2);
    tick();
    check_writes("ign_start", 2, 8'hA0, {16'h0, 16'h0, 16'h32, 16'h31});

    // Back-pressure: three stalled cycles in the middle of a drain
    clear_writes();
    start_run(8'h30, 8'd4);
    drive(4'b1111, {16'h104, 16'h103, 16'h102, 16'h101});
    tick();
    valid_in = '0;
    tick();
    out_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      tick();
      check("stall_we", out_we, 1);
      check("stall_addr", out_addr, 8'h31);
      check("stall_data", out_data, 16'h102);
    end
    out_ready = 1'b1;
    wait_done(20, cyc);
    check("stall_done_seen", (cyc != 0), 1);
    tick();
    check_writes("stall", 4, 8'h30, {16'h104, 16'h103, 16'h102, 16'h101});

    // A slot freed on the same edge as a capture takes that capture
    clear_writes();
    out_ready = 1'b0;
    start_run(8'hC0, 8'd3);
    drive(4'b0001, {16'h0, 16'h0, 16'h0, 16'hB1});
    tick();
    drive(4'b0001, {16'h0, 16'h0, 16'h0, 16'hB2});
    tick();
    out_ready = 1'b1;
    drive(4'b0001, {16'h0, 16'h0, 16'h0, 16'hB3});
    tick();
    valid_in = '0;
    check("reuse_ovf", overflow, 0);
    wait_done(20, cyc);
    check("reuse_done_seen", (cyc != 0), 1);
    tick();
    check_writes("reuse", 3, 8'hC0, {16'h0, 16'hB3, 16'hB2, 16'hB1});

    // Overflow: third capture while both slots are held is dropped
    clear_writes();
    out_ready = 1'b0;
    start_run(8'h80, 8'd2);
    drive(4'b0001, {16'h0, 16'h0, 16'h0, 16'hA1});
    tick();
    drive(4'b0001, {16'h0, 16'h0, 16'h0, 16'hA2});
    tick();
    check("ovf_before", overflow, 0);
    drive(4'b0001, {16'h0, 16'h0, 16'h0, 16'hA3});
    tick();
    valid_in = '0;
    check("ovf_set", overflow, 1);
    tick();
    check("ovf_sticky", overflow, 1);
    out_ready = 1'b1;
    wait_done(20, cyc);
    check("ovf_done_seen", (cyc != 0), 1);
    tick();
    check("ovf_after_done", overflow, 1);
    check_writes("ovf", 2, 8'h80, {16'h0, 16'h0, 16'hA2, 16'hA1});

    // Reset in the middle of a run aborts it immediately
    clear_writes();
    start_run(8'h90, 8'd4);
    check("ovf_cleared_by_start", overflow, 0);
    drive(4'b1111, {16'h94, 16'h93, 16'h92, 16'h91});
    tick();
    valid_in = '0;
    check("abort_we_before", out_we, 1);
    #2 rst = 1'b0;
    #1;
    check("abort_out_we", out_we, 0);
    check("abort_out_addr", out_addr, 0);
    check("abort_out_data", out_data, 0);
    check("abort_busy", busy, 0);
    tick(); tick();
    rst = 1'b1;
    tick(); tick(); tick();
    check("abort_no_writes", wr_addr_q.size(), 0);
    check("abort_idle_we", out_we, 0);

    // First run after reset release starts fresh
    clear_writes();
    start_run(8'h05, 8'd1);
    drive(4'b0001, {16'h0, 16'h0, 16'h0, 16'h1234});
    tick();
    valid_in = '0;
    wait_done(20, cyc);
    check("fresh_cycles", cyc, 1);
    tick();
    check_writes("fresh", 1, 8'h05, {16'h0, 16'h0, 16'h0, 16'h1234});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
